mux_sel_ctrl: RTL

- Round-robin select generator sitting directly upstream of the 4:1 mux (`mul`).
- Arbitrates four request lines and drives the mux selects `s1`/`s0` plus a `valid` qualifier.
- Holds each grant until the consumer signals `done`, the granted request drops, or a dwell timeout expires.
- Inserts a one-cycle dead gap between grants so the downstream never sees back-to-back select changes with `valid` high.

---
 rtl/mux_sel_ctrl_pkg.sv | 17 +
 rtl/mux_sel_ctrl_if.sv | 37 +++
 rtl/mux_sel_ctrl_rr_pick4.sv | 27 ++
 rtl/mux_sel_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/mux_sel_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_sel_ctrl_pkg : shared state encodings and channel count
// Rev 1.0
// ---------------------------------------------------------------------------
package mux_sel_ctrl_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage : mux_sel_ctrl_pkg
`default_nettype wire

// File: rtl/mux_sel_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_sel_ctrl_if : request/select bundle between arbiter and mux consumer
// Rev 1.0
// ---------------------------------------------------------------------------
interface mux_sel_ctrl_if;
  import mux_sel_ctrl_pkg::*;

  logic [NCH-1:0] req;
  logic           done;
  logic           s1;
  logic           s0;
  logic           valid;
  logic [NCH-1:0] grant;
  logic           timeout;

  modport master (
    input  req,
    input  done,
    output s1,
    output s0,
    output valid,
    output grant,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  s1,
    input  s0,
    input  valid,
    input  grant,
    input  timeout
  );
endinterface : mux_sel_ctrl_if
`default_nettype wire

// File: rtl/mux_sel_ctrl_rr_pick4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick4 : combinational round-robin pick, search starts at last+1
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick4 (
  input  wire logic [3:0] req,
  input  wire logic [1:0] last,
  output logic            any,
  output logic [1:0]      win
);

  logic [1:0] w_cand;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    any    = |req;
    win    = last;
    w_cand = last;
    for (int i = 4; i >= 1; i--) begin
      w_cand = last + 2'(i);
      if (req[w_cand]) win = w_cand;
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux_sel_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_sel_ctrl : round-robin 4:1 mux select generator with dwell limit and gap
// Rev 1.0
// ---------------------------------------------------------------------------
module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  mux_sel_ctrl_if.master  bus
);

  localparam logic [DWELL_W-1:0] C_CNT_LOAD = DWELL_W'(DWELL - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_sel,   w_sel_nxt;
  logic [NCH-1:0]     r_grant, w_grant_nxt;
  logic               r_to,    w_to_nxt;
  logic [DWELL_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]         r_last,  w_last_nxt;

  logic               w_any;
  logic [1:0]         w_win;
  logic               w_end;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (r_last),
    .any  (w_any),
    .win  (w_win)
  );

  // Priority order matters only for timeout: done or a dropped request wins.
  assign w_end = bus.done || !bus.req[r_last] || (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'b00;
      r_grant <= '0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_to    <= w_to_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_end) w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = w_any ? ST_GRANT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt   = r_sel;
    w_grant_nxt = '0;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_any) begin
          w_sel_nxt   = w_win;
          w_grant_nxt = 4'b0001 << w_win;
          w_cnt_nxt   = C_CNT_LOAD;
          w_last_nxt  = w_win;
        end
      end
      ST_GRANT: begin
        if (!w_end) begin
          w_grant_nxt = r_grant;
          w_cnt_nxt   = r_cnt - 1'b1;
        end else begin
          w_to_nxt = !bus.done && bus.req[r_last];
        end
      end
      default: ;
    endcase
  end

  assign bus.s1      = r_sel[1];
  assign bus.s0      = r_sel[0];
  assign bus.valid   = (r_state == ST_GRANT);
  assign bus.grant   = r_grant;
  assign bus.timeout = r_to;

endmodule : mux_sel_ctrl
`default_nettype wire
